// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared wire-format constants and FSM encoding for the CPU memory bridge
package mem_bridge_pkg;
  localparam int MSG_BIT = 72;
  localparam int LEN_BIT = 5;
  localparam logic [LEN_BIT-1:0] LEN_READ = 5'd5;
  localparam logic [LEN_BIT-1:0] LEN_WRITE = 5'd9;
  localparam logic [LEN_BIT-1:0] LEN_RESP = 5'd4;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;
  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_e;
endpackage

// File: rtl/mem_msg_pack.sv
// mem_msg_pack: builds the outgoing read/write message length and payload
module mem_msg_pack
  import mem_bridge_pkg::*;
(
  input  logic               we_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  input  logic [3:0]         mask_i,
  output logic [LEN_BIT-1:0] length_o,
  output logic [MSG_BIT-1:0] payload_o
);
  // read carries only the address; write carries data, address and byte mask
  always_comb begin
    length_o = we_i ? LEN_WRITE : LEN_READ;
    payload_o = we_i ? {4'h0, mask_i, addr_i, wdata_i} : {40'h0, addr_i};
  end
endmodule

// File: rtl/mem_uart_bridge.sv
// mem_uart_bridge: serialises IF/MEM requests into framed messages and returns read responses
module mem_uart_bridge
  import mem_bridge_pkg::*;
#(
  parameter int TIMEOUT = 0,
  parameter int CNT_BIT = 16
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               if_req,
  input  logic [31:0]        if_addr,
  output logic               if_done,
  output logic [31:0]        if_rdata,
  input  logic               mem_req,
  input  logic               mem_we,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  input  logic [3:0]         mem_mask,
  output logic               mem_done,
  output logic [31:0]        mem_rdata,
  output logic               tx_flag,
  output logic [LEN_BIT-1:0] tx_length,
  output logic [MSG_BIT-1:0] tx_data,
  input  logic               tx_ready,
  input  logic               rx_valid,
  input  logic [LEN_BIT-1:0] rx_length,
  input  logic [MSG_BIT-1:0] rx_data,
  output logic               rx_flag,
  output logic               err
);
  localparam logic [CNT_BIT-1:0] TO_CNT = CNT_BIT'(TIMEOUT);
  state_e state_q, state_d;
  logic is_mem_q, is_mem_d, we_q, we_d, to_q, to_d;
  logic tx_flag_q, tx_flag_d, rx_flag_q, rx_flag_d, err_q, err_d;
  logic if_done_q, if_done_d, mem_done_q, mem_done_d;
  logic [31:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic [CNT_BIT-1:0] cnt_q, cnt_d, cnt_inc;
  logic [LEN_BIT-1:0] tx_length_q, tx_length_d, pk_len;
  logic [MSG_BIT-1:0] tx_data_q, tx_data_d, pk_data;
  logic rx_take, new_we, unused_ok;
  assign rx_take = rx_valid && !rx_flag_q;
  assign new_we = mem_req && mem_we;
  assign cnt_inc = cnt_q + CNT_BIT'(1);
  assign unused_ok = ^rx_data[MSG_BIT-1:32];
  mem_msg_pack u_pack (
    .we_i     (new_we),
    .addr_i   (mem_req ? mem_addr : if_addr),
    .wdata_i  (mem_wdata),
    .mask_i   (mem_mask),
    .length_o (pk_len),
    .payload_o(pk_data)
  );
  assign if_done = if_done_q;
  assign if_rdata = if_rdata_q;
  assign mem_done = mem_done_q;
  assign mem_rdata = mem_rdata_q;
  assign tx_flag = tx_flag_q;
  assign tx_length = tx_length_q;
  assign tx_data = tx_data_q;
  assign rx_flag = rx_flag_q;
  assign err = err_q;
  // next state: one transaction at a time; any response outside WAIT is drained as an error
  always_comb begin
    state_d = state_q;
    is_mem_d = is_mem_q;
    we_d = we_q;
    to_d = to_q;
    cnt_d = cnt_q;
    tx_length_d = tx_length_q;
    tx_data_d = tx_data_q;
    if_rdata_d = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    tx_flag_d = 1'b0;
    rx_flag_d = rx_take;
    err_d = rx_take;
    if_done_d = 1'b0;
    mem_done_d = 1'b0;
    case (state_q)
      IDLE: if (mem_req || if_req) begin
        is_mem_d = mem_req;
        we_d = new_we;
        to_d = 1'b0;
        tx_length_d = pk_len;
        tx_data_d = pk_data;
        state_d = (new_we && mem_mask == 4'h0) ? DONE : SEND;
      end
      SEND: if (tx_ready) begin
        tx_flag_d = 1'b1;
        cnt_d = '0;
        state_d = we_q ? DONE : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        err_d = 1'b0;
        if (rx_take) begin
          cnt_d = '0;
          err_d = rx_length != LEN_RESP;
          mem_rdata_d = (is_mem_q && rx_length == LEN_RESP) ? rx_data[31:0] : mem_rdata_q;
          if_rdata_d = (!is_mem_q && rx_length == LEN_RESP) ? rx_data[31:0] : if_rdata_q;
          state_d = rx_length == LEN_RESP ? DONE : WAIT;
        end else if (TIMEOUT != 0 && cnt_inc == TO_CNT) begin
          to_d = 1'b1;
          mem_rdata_d = is_mem_q ? TIMEOUT_DATA : mem_rdata_q;
          if_rdata_d = is_mem_q ? if_rdata_q : TIMEOUT_DATA;
          state_d = DONE;
        end
      end
      DONE: begin
        err_d = rx_take || to_q;
        if_done_d = !is_mem_q;
        mem_done_d = is_mem_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      is_mem_q <= 1'b0;
      we_q <= 1'b0;
      to_q <= 1'b0;
      cnt_q <= '0;
      tx_length_q <= '0;
      tx_data_q <= '0;
      if_rdata_q <= '0;
      mem_rdata_q <= '0;
      tx_flag_q <= 1'b0;
      rx_flag_q <= 1'b0;
      err_q <= 1'b0;
      if_done_q <= 1'b0;
      mem_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_mem_q <= is_mem_d;
      we_q <= we_d;
      to_q <= to_d;
      cnt_q <= cnt_d;
      tx_length_q <= tx_length_d;
      tx_data_q <= tx_data_d;
      if_rdata_q <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      tx_flag_q <= tx_flag_d;
      rx_flag_q <= rx_flag_d;
      err_q <= err_d;
      if_done_q <= if_done_d;
      mem_done_q <= mem_done_d;
    end
  end
endmodule

// File: tb/tb_mem_uart_bridge.sv
// tb_mem_uart_bridge: directed scenarios with a transaction-level expected-message/completion model
module tb_mem_uart_bridge;
  typedef struct {
    logic [4:0]  len;
    logic [71:0] data;
  } msg_t;
  typedef struct {
    bit          is_mem;
    bit          chk;
    logic [31:0] data;
  } done_t;
  logic clk = 1'b0;
  logic RST = 1'b1;
  logic if_req, mem_req, mem_we, tx_ready, rx_valid;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [3:0] mem_mask;
  logic [4:0] rx_length;
  logic [71:0] rx_data;
  logic if_done, mem_done, tx_flag, rx_flag, err;
  logic [31:0] if_rdata, mem_rdata;
  logic [4:0] tx_length;
  logic [71:0] tx_data;
  int nchk = 0;
  int nerr = 0;
  int tx_cnt = 0;
  int rx_cnt = 0;
  int err_cnt = 0;
  msg_t exp_msg_q[$];
  done_t exp_done_q[$];
  always #5 clk = ~clk;
  mem_uart_bridge #(.TIMEOUT(20), .CNT_BIT(16)) dut (
    .clk(clk), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mask(mem_mask), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .tx_flag(tx_flag), .tx_length(tx_length), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_length(rx_length), .rx_data(rx_data), .rx_flag(rx_flag), .err(err)
  );
  task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask
  function automatic msg_t model_msg(bit we, logic [31:0] addr, logic [31:0] wdata, logic [3:0] mask);
    msg_t m;
    m.len = we ? 5'd9 : 5'd5;
    m.data = we ? (({68'd0, mask} << 64) | ({40'd0, addr} << 32) | {40'd0, wdata}) : {40'd0, addr};
    return m;
  endfunction
  function automatic done_t mk_done(bit is_mem, bit c, logic [31:0] d);
    done_t e;
    e.is_mem = is_mem;
    e.chk = c;
    e.data = d;
    return e;
  endfunction
  function automatic logic sig(int w);
    return w == 0 ? tx_flag : w == 1 ? rx_flag : w == 2 ? if_done : mem_done;
  endfunction
  task automatic step();
    @(negedge clk);
  endtask
  task automatic wait_sig(input int which, input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sig(which) && n < maxc);
    if (!sig(which)) chk($sformatf("wait_timeout_%0d", which), 0, 1);
  endtask
  task automatic issue_if(input logic [31:0] a);
    if_req = 1'b1;
    if_addr = a;
    exp_msg_q.push_back(model_msg(1'b0, a, 32'h0, 4'h0));
  endtask
  task automatic issue_mem(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    mem_req = 1'b1;
    mem_we = we;
    mem_addr = a;
    mem_wdata = d;
    mem_mask = m;
    if (!(we && m == 4'h0)) exp_msg_q.push_back(model_msg(we, a, d, m));
  endtask
  task automatic respond(input logic [4:0] len, input logic [71:0] d);
    rx_valid = 1'b1;
    rx_length = len;
    rx_data = d;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, {if_done, mem_done, tx_flag, rx_flag, err, tx_length}, 0);
    chk({tag, "_txdata"}, tx_data, 0);
    chk({tag, "_rdata"}, {if_rdata, mem_rdata}, 0);
  endtask
  // compare process: every strobe and completion is checked against the model queues
  initial begin
    msg_t m;
    done_t e;
    logic prev_tx, prev_rx, prev_done;
    prev_tx = 1'b0;
    prev_rx = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!RST) begin
        if (tx_flag) begin
          tx_cnt++;
          chk("tx_single", prev_tx, 0);
          if (exp_msg_q.size() == 0) chk("tx_unexpected", 1, 0);
          else begin
            m = exp_msg_q.pop_front();
            chk("tx_length", tx_length, m.len);
            chk("tx_data", tx_data, m.data);
          end
        end
        if (rx_flag) begin
          rx_cnt++;
          chk("rx_flag_gap", prev_rx, 0);
        end
        if (err) err_cnt++;
        if (if_done || mem_done) begin
          chk("done_single", prev_done, 0);
          chk("done_both", if_done && mem_done, 0);
          if (exp_done_q.size() == 0) chk("done_unexpected", 1, 0);
          else begin
            e = exp_done_q.pop_front();
            chk("done_port", mem_done, e.is_mem);
            if (e.chk) chk("done_rdata", mem_done ? mem_rdata : if_rdata, e.data);
          end
        end
      end
      prev_tx = tx_flag && !RST;
      prev_rx = rx_flag && !RST;
      prev_done = (if_done || mem_done) && !RST;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1);
  end
  initial begin
    int n, r_rx, r_err, r_tx;
    if_req = 0; mem_req = 0; mem_we = 0; rx_valid = 0; tx_ready = 1;
    if_addr = 0; mem_addr = 0; mem_wdata = 0; mem_mask = 0; rx_length = 0; rx_data = 0;
    repeat (3) step();
    chk_reset("reset");
    RST = 1'b0;
    step();
    // fetch read
    r_rx = rx_cnt; r_err = err_cnt;
    issue_if(32'h100);
    wait_sig(0, 10, n);
    chk("t1_tx_lat", n, 2);
    chk("t1_tx_len", tx_length, 5);
    chk("t1_tx_data", tx_data, 72'h100);
    respond(5'd4, 72'hAB_CDEF0123_00A00093);
    exp_done_q.push_back(mk_done(1'b0, 1'b1, 32'h00A00093));
    wait_sig(1, 10, n);
    chk("t1_rx_lat", n, 1);
    rx_valid = 1'b0;
    wait_sig(2, 10, n);
    chk("t1_done_lat", n, 1);
    chk("t1_if_rdata", if_rdata, 32'h00A00093);
    if_req = 1'b0;
    repeat (3) step();
    chk("t1_rdata_hold", if_rdata, 32'h00A00093);
    chk("t1_rx_count", rx_cnt - r_rx, 1);
    chk("t1_err_count", err_cnt - r_err, 0);
    // byte write
    r_rx = rx_cnt;
    issue_mem(1'b1, 32'h104, 32'h41, 4'b0001);
    exp_done_q.push_back(mk_done(1'b1, 1'b0, 32'h0));
    wait_sig(0, 10, n);
    chk("t2_tx_lat", n, 2);
    chk("t2_tx_len", tx_length, 9);
    chk("t2_tx_data", tx_data, 72'h1_00000104_00000041);
    wait_sig(3, 10, n);
    chk("t2_done_lat", n, 1);
    mem_req = 1'b0; mem_we = 1'b0;
    repeat (2) step();
    chk("t2_rx_count", rx_cnt - r_rx, 0);
    // arbitration under backpressure
    tx_ready = 1'b0;
    issue_mem(1'b0, 32'h300, 32'h0, 4'h0);
    issue_if(32'h200);
    r_tx = tx_cnt;
    repeat (5) step();
    chk("t3_stall", tx_cnt - r_tx, 0);
    tx_ready = 1'b1;
    wait_sig(0, 10, n);
    chk("t3_tx_lat", n, 1);
    chk("t3_tx_first", tx_data, 72'h300);
    respond(5'd4, 72'hCAFE0001);
    exp_done_q.push_back(mk_done(1'b1, 1'b1, 32'hCAFE0001));
    wait_sig(1, 10, n);
    rx_valid = 1'b0;
    wait_sig(3, 10, n);
    chk("t3_mem_rdata", mem_rdata, 32'hCAFE0001);
    mem_req = 1'b0;
    wait_sig(0, 10, n);
    chk("t3_if_after_done", n, 2);
    chk("t3_tx_second", tx_data, 72'h200);
    respond(5'd4, 72'hBEEF0002);
    exp_done_q.push_back(mk_done(1'b0, 1'b1, 32'hBEEF0002));
    wait_sig(1, 10, n);
    rx_valid = 1'b0;
    wait_sig(2, 10, n);
    chk("t3_if_rdata", if_rdata, 32'hBEEF0002);
    if_req = 1'b0;
    step();
    // malformed response followed by a good one
    r_rx = rx_cnt; r_err = err_cnt;
    issue_mem(1'b0, 32'h400, 32'h0, 4'h0);
    wait_sig(0, 10, n);
    respond(5'd9, 72'h55_AAAAAAAA_BBBBBBBB);
    wait_sig(1, 10, n);
    chk("t4_bad_lat", n, 1);
    chk("t4_err_bad", err, 1);
    respond(5'd4, 72'h12345678);
    exp_done_q.push_back(mk_done(1'b1, 1'b1, 32'h12345678));
    step();
    chk("t4_rx_gap", rx_flag, 0);
    step();
    chk("t4_rx_good", rx_flag, 1);
    chk("t4_err_good", err, 0);
    rx_valid = 1'b0;
    wait_sig(3, 10, n);
    chk("t4_done_lat", n, 1);
    chk("t4_mem_rdata", mem_rdata, 32'h12345678);
    mem_req = 1'b0;
    step();
    chk("t4_err_count", err_cnt - r_err, 1);
    chk("t4_rx_count", rx_cnt - r_rx, 2);
    // timeout then stray response
    issue_mem(1'b0, 32'h500, 32'h0, 4'h0);
    wait_sig(0, 10, n);
    r_err = err_cnt;
    exp_done_q.push_back(mk_done(1'b1, 1'b1, 32'hDEADBEEF));
    wait_sig(3, 40, n);
    chk("t5_timeout_lat", n, 21);
    chk("t5_err_with_done", err, 1);
    chk("t5_mem_rdata", mem_rdata, 32'hDEADBEEF);
    mem_req = 1'b0;
    step();
    chk("t5_err_count", err_cnt - r_err, 1);
    r_err = err_cnt;
    respond(5'd4, 72'h99);
    wait_sig(1, 10, n);
    chk("t5_stray_lat", n, 1);
    chk("t5_stray_err", err, 1);
    rx_valid = 1'b0;
    repeat (2) step();
    chk("t5_stray_err_count", err_cnt - r_err, 1);
    chk("t5_stray_discard", mem_rdata, 32'hDEADBEEF);
    // reset during WAIT
    issue_mem(1'b0, 32'h600, 32'h0, 4'h0);
    wait_sig(0, 10, n);
    repeat (2) step();
    RST = 1'b1;
    #1;
    chk_reset("t6_reset");
    step();
    mem_req = 1'b0;
    step();
    RST = 1'b0;
    step();
    respond(5'd4, 72'h66);
    wait_sig(1, 10, n);
    chk("t6_late_lat", n, 1);
    chk("t6_late_err", err, 1);
    rx_valid = 1'b0;
    step();
    chk("t6_late_discard", mem_rdata, 0);
    issue_if(32'h700);
    wait_sig(0, 10, n);
    chk("t6_tx_lat", n, 2);
    respond(5'd4, 72'h77777777);
    exp_done_q.push_back(mk_done(1'b0, 1'b1, 32'h77777777));
    wait_sig(1, 10, n);
    rx_valid = 1'b0;
    wait_sig(2, 10, n);
    chk("t6_if_rdata", if_rdata, 32'h77777777);
    if_req = 1'b0;
    step();
    r_tx = tx_cnt;
    issue_mem(1'b1, 32'h800, 32'h12, 4'h0);
    exp_done_q.push_back(mk_done(1'b1, 1'b0, 32'h0));
    wait_sig(3, 10, n);
    chk("t6_mask0_lat", n, 2);
    mem_req = 1'b0; mem_we = 1'b0;
    repeat (2) step();
    chk("t6_mask0_no_tx", tx_cnt - r_tx, 0);
    chk("queues_empty", exp_msg_q.size() + exp_done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
